// File: rtl/aes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctrl
// Purpose  : AES key-expansion and round sequencer for 128/192/256-bit keys.
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctrl #(
    parameter int K = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       kexp_en,
    output logic [5:0] kexp_idx,
    output logic [1:0] kexp_mode,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic [1:0] state_sel,
    output logic       state_en
);
    localparam int NK = K / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] C_NK      = 6'(NK);
    localparam logic [5:0] C_LAST_W  = 6'(NW - 1);
    localparam logic [3:0] C_NR      = 4'(NR);
    localparam logic [3:0] C_LAST_R  = 4'(NR - 1);
    localparam logic [2:0] C_LAST_PH = 3'(NK - 1);
    localparam logic       C_K256    = (K == 256);

    if (K != 128 && K != 192 && K != 256) begin : g_bad_k
        $error("aes_ctrl: K must be 128, 192 or 256");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_load_q;
    logic [2:0] r_phase;    // word index modulo NK
    logic [7:0] r_rc;       // rcon for the next RotWord word

    logic       w_start, w_busy, w_done, w_kexp_en, w_sen;
    logic [5:0] w_idx;
    logic [1:0] w_mode, w_sel;
    logic [7:0] w_rcon, w_rc, w_rc_base;
    logic [3:0] w_round;
    logic [2:0] w_phase;

    function automatic logic [7:0] f_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    always_comb begin
        w_start     = r_load_q & ~load;
        w_state_nxt = r_state;
        w_idx       = kexp_idx;
        w_round     = round;
        w_sel       = 2'b00;
        w_mode      = 2'b00;
        w_rcon      = 8'h00;
        w_phase     = r_phase;
        w_rc_base   = r_rc;
        w_rc        = r_rc;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_nxt = S_KEXP;
                    w_idx       = C_NK;
                    w_phase     = 3'd0;
                    w_rc_base   = 8'h01;
                end else if (load) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_KEXP: begin
                if (load) begin
                    w_state_nxt = S_IDLE;
                end else if (kexp_idx == C_LAST_W) begin
                    w_state_nxt = S_INIT;
                    w_round     = 4'd0;
                    w_sel       = 2'b01;
                end else begin
                    w_idx   = kexp_idx + 6'd1;
                    w_phase = (r_phase == C_LAST_PH) ? 3'd0 : r_phase + 3'd1;
                end
            end
            S_INIT: begin
                if (load) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ROUND;
                    w_round     = 4'd1;
                    w_sel       = 2'b10;
                end
            end
            S_ROUND: begin
                if (load) begin
                    w_state_nxt = S_IDLE;
                end else if (round == C_LAST_R) begin
                    w_state_nxt = S_FINAL;
                    w_round     = C_NR;
                    w_sel       = 2'b11;
                end else begin
                    w_round = round + 4'd1;
                    w_sel   = 2'b10;
                end
            end
            S_FINAL: begin
                w_state_nxt = load ? S_IDLE : S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy    = (w_state_nxt inside {S_KEXP, S_INIT, S_ROUND, S_FINAL});
        w_done    = (w_state_nxt == S_DONE);
        w_kexp_en = (w_state_nxt == S_KEXP);
        w_sen     = (w_sel != 2'b00);
        // The per-word operation is decoded for the word about to be written.
        if (w_kexp_en) begin
            if (w_phase == 3'd0) begin
                w_mode = 2'b01;
                w_rcon = w_rc_base;
                w_rc   = f_xtime(w_rc_base);
            end else if (C_K256 && w_phase == 3'd4) begin
                w_mode = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_load_q  <= 1'b0;
            r_phase   <= 3'd0;
            r_rc      <= 8'h01;
            busy      <= 1'b0;
            done      <= 1'b0;
            kexp_en   <= 1'b0;
            kexp_idx  <= 6'd0;
            kexp_mode <= 2'b00;
            rcon      <= 8'h00;
            round     <= 4'd0;
            state_sel <= 2'b00;
            state_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_load_q  <= load;
            r_phase   <= w_phase;
            r_rc      <= w_rc;
            busy      <= w_busy;
            done      <= w_done;
            kexp_en   <= w_kexp_en;
            kexp_idx  <= w_idx;
            kexp_mode <= w_mode;
            rcon      <= w_rcon;
            round     <= w_round;
            state_sel <= w_sel;
            state_en  <= w_sen;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctrl
// Purpose  : Self-checking bench for aes_ctrl with K = 128, 192 and 256.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctrl;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [2:0][25:0]  o_vec;   // {busy,done,en,idx[6],mode[2],rcon[8],round[4],sel[2],sen}

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_ctrl #(.K(128 + 64 * g)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .busy     (o_vec[g][25]),
            .done     (o_vec[g][24]),
            .kexp_en  (o_vec[g][23]),
            .kexp_idx (o_vec[g][22:17]),
            .kexp_mode(o_vec[g][16:15]),
            .rcon     (o_vec[g][14:7]),
            .round    (o_vec[g][6:3]),
            .state_sel(o_vec[g][2:1]),
            .state_en (o_vec[g][0])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] rcon_t [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Reference model: 0 idle, 1 running (m_c cycles since start), 2 done
    int m_st [3]  = '{0, 0, 0};
    int m_c  [3]  = '{0, 0, 0};
    int m_idx[3]  = '{0, 0, 0};
    int m_rnd[3]  = '{0, 0, 0};
    bit m_lq      = 1'b0;

    function automatic int f_nk(int g); return 4 + 2 * g; endfunction
    function automatic int f_nr(int g); return f_nk(g) + 6; endfunction
    function automatic int f_e(int g);  return 4 * (f_nr(g) + 1) - f_nk(g); endfunction

    function automatic logic [25:0] pk(bit b, bit d, bit e, int i, int m,
                                       logic [7:0] rc, int r, int s, bit se);
        return {b, d, e, 6'(i), 2'(m), rc, 4'(r), 2'(s), se};
    endfunction

    task automatic model_update();
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                m_st[g] = 0; m_idx[g] = 0; m_rnd[g] = 0;
            end else begin
                if (m_st[g] == 1) begin
                    if (load) m_st[g] = 0;
                    else begin
                        m_c[g]++;
                        if (m_c[g] > f_e(g) + f_nr(g)) m_st[g] = 2;
                    end
                end else if (m_lq && !load) begin
                    m_st[g] = 1; m_c[g] = 0;
                end else if (m_st[g] == 2 && load) begin
                    m_st[g] = 0;
                end
                if (m_st[g] == 1) begin
                    if (m_c[g] < f_e(g)) m_idx[g] = f_nk(g) + m_c[g];
                    else                 m_rnd[g] = m_c[g] - f_e(g);
                end
            end
        end
        m_lq = reset ? 1'b0 : load;
    endtask

    function automatic logic [25:0] model_exp(int g);
        int i, m, r, s;
        logic [7:0] rc;
        bit en, se;
        en = 0; se = 0; m = 0; s = 0; rc = 8'h00;
        if (m_st[g] == 1) begin
            if (m_c[g] < f_e(g)) begin
                en = 1;
                i  = f_nk(g) + m_c[g];
                if (i % f_nk(g) == 0) begin
                    m  = 1;
                    rc = rcon_t[i / f_nk(g) - 1];
                end else if (f_nk(g) == 8 && i % 8 == 4) begin
                    m = 2;
                end
            end else begin
                se = 1;
                r  = m_c[g] - f_e(g);
                s  = (r == 0) ? 1 : (r == f_nr(g)) ? 3 : 2;
            end
        end
        return pk(m_st[g] == 1, m_st[g] == 2, en, m_idx[g], m, rc, m_rnd[g], s, se);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // One clock: model follows the sampled inputs, then every DUT is compared.
    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        for (int g = 0; g < 3; g++) chk($sformatf("model_k%0d", 128 + 64 * g),
                                         32'(o_vec[g]), 32'(model_exp(g)));
    endtask

    typedef struct {
        int         c;
        bit         busy, done, en;
        int         idx, mode;
        logic [7:0] rc;
        int         rnd, sel;
        bit         sen;
    } vec_t;

    vec_t       tbl[$];
    logic [25:0] tr [3][70];
    int          first_done, busy_cnt, n01, n10, k;
    int          exp_done [3] = '{51, 59, 67};
    int          exp_n01  [3] = '{10, 8, 7};
    int          exp_n10  [3] = '{0, 0, 6};

    initial begin
        tbl.push_back('{0,  1, 0, 1, 4,  1, 8'h01, 0,  0, 0});
        tbl.push_back('{1,  1, 0, 1, 5,  0, 8'h00, 0,  0, 0});
        tbl.push_back('{4,  1, 0, 1, 8,  1, 8'h02, 0,  0, 0});
        tbl.push_back('{12, 1, 0, 1, 16, 1, 8'h08, 0,  0, 0});
        tbl.push_back('{32, 1, 0, 1, 36, 1, 8'h1B, 0,  0, 0});
        tbl.push_back('{36, 1, 0, 1, 40, 1, 8'h36, 0,  0, 0});
        tbl.push_back('{39, 1, 0, 1, 43, 0, 8'h00, 0,  0, 0});
        tbl.push_back('{40, 1, 0, 0, 43, 0, 8'h00, 0,  1, 1});
        tbl.push_back('{41, 1, 0, 0, 43, 0, 8'h00, 1,  2, 1});
        tbl.push_back('{49, 1, 0, 0, 43, 0, 8'h00, 9,  2, 1});
        tbl.push_back('{50, 1, 0, 0, 43, 0, 8'h00, 10, 3, 1});
        tbl.push_back('{51, 0, 1, 0, 43, 0, 8'h00, 10, 0, 0});
        tbl.push_back('{58, 0, 1, 0, 43, 0, 8'h00, 10, 0, 0});

        // Reset state
        repeat (3) step();
        for (int g = 0; g < 3; g++) chk("reset_state", 32'(o_vec[g]), 32'd0);

        // Full run on all three key sizes
        reset = 1'b0;
        load  = 1'b1;
        repeat (5) step();
        load = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step();
            for (int g = 0; g < 3; g++) tr[g][c] = o_vec[g];
        end
        foreach (tbl[j]) begin
            chk($sformatf("k128_vec_c%0d", tbl[j].c), 32'(tr[0][tbl[j].c]),
                32'(pk(tbl[j].busy, tbl[j].done, tbl[j].en, tbl[j].idx, tbl[j].mode,
                       tbl[j].rc, tbl[j].rnd, tbl[j].sel, tbl[j].sen)));
        end
        for (int g = 0; g < 3; g++) begin
            first_done = -1; busy_cnt = 0; n01 = 0; n10 = 0;
            for (int c = 69; c >= 0; c--) if (tr[g][c][24]) first_done = c;
            for (int c = 0; c < 70; c++) begin
                if (tr[g][c][25]) busy_cnt++;
                if (tr[g][c][16:15] == 2'b01) begin
                    chk("rcon_seq", 32'(tr[g][c][14:7]), 32'(rcon_t[n01]));
                    chk("rcon_idx", 32'(tr[g][c][22:17]), 32'(f_nk(g) * (n01 + 1)));
                    n01++;
                end
                if (tr[g][c][16:15] == 2'b10) begin
                    chk("subword_idx", 32'(tr[g][c][22:17]), 32'(12 + 8 * n10));
                    n10++;
                end
            end
            chk($sformatf("done_edge_k%0d", 128 + 64 * g), 32'(first_done), 32'(exp_done[g]));
            chk("busy_cycles", 32'(busy_cnt), 32'(exp_done[g]));
            chk("n_rotword", 32'(n01), 32'(exp_n01[g]));
            chk("n_subword", 32'(n10), 32'(exp_n10[g]));
        end
        chk("k192_final_round", 32'(tr[1][58][6:1]), 32'({4'd12, 2'b11}));

        // In DONE: load clears done, a one-cycle pulse restarts key expansion
        load = 1'b1;
        step();
        for (int g = 0; g < 3; g++) chk("done_clear", 32'(o_vec[g][24]), 32'd0);
        load = 1'b0;
        step();
        for (int g = 0; g < 3; g++)
            chk("restart_kexp", 32'(o_vec[g][23:7]), 32'({1'b1, 6'(f_nk(g)), 2'b01, 8'h01}));

        // Abort during round 5
        k = 0;
        while (!(o_vec[0][6:3] == 4'd5 && o_vec[0][2:1] == 2'b10) && k < 100) begin
            step(); k++;
        end
        chk("abort_reach_r5", 32'(k < 100), 32'd1);
        load = 1'b1;
        step();
        chk("abort_busy", 32'(o_vec[0][25]), 32'd0);
        chk("abort_state_en", 32'(o_vec[0][0]), 32'd0);
        repeat (3) begin
            step();
            chk("abort_no_done", 32'(o_vec[0][24]), 32'd0);
        end
        load = 1'b0;
        step();
        for (int g = 0; g < 3; g++) chk("abort_rcon_restart", 32'(o_vec[g][14:7]), 32'h01);
        k = 0;
        while (!o_vec[0][24] && k < 80) begin step(); k++; end
        chk("rerun_done", 32'(o_vec[0][24]), 32'd1);

        // Reset during key expansion
        load = 1'b1; step();
        load = 1'b0; step();
        repeat (3) step();
        reset = 1'b1; step();
        for (int g = 0; g < 3; g++) chk("reset_in_kexp", 32'(o_vec[g]), 32'd0);
        reset = 1'b0; step();

        // Reset on the same edge that samples start
        load = 1'b1; step();
        load = 1'b0; reset = 1'b1; step();
        for (int g = 0; g < 3; g++) chk("reset_vs_start", 32'(o_vec[g]), 32'd0);
        reset = 1'b0; step();
        for (int g = 0; g < 3; g++) chk("stay_idle", 32'(o_vec[g]), 32'd0);

        // Randomized load pulses, aborts and resets against the model
        for (int it = 0; it < 40; it++) begin
            load = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            load = 1'b0;
            repeat ($urandom_range(0, 75)) step();
            if ($urandom_range(0, 7) == 0) begin
                load  = 1'($urandom_range(0, 1));
                reset = 1'b1;
                step();
                reset = 1'b0;
                load  = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
